// File: rtl/sobel_stage.sv
// sobel_stage
//   Streaming 3x3 Sobel edge detector between an SPI pixel deserializer and
//   a frame-buffer writer. Pixels arrive in raster order. Each interior
//   window produces one 2-bit edge code, addressed by its centre pixel.
//
//   Build option: SOBEL_THRESHOLD_EN
//     defined   : out_pix = 2'b11 when the saturated magnitude >= THRESH,
//                 otherwise 2'b00
//     undefined : out_pix = saturated magnitude[7:6]; THRESH is unused
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   in_valid   : upstream presents a pixel
//   in_sof     : in_pix is pixel (0,0) of a new frame
//   in_pix     : 8-bit grayscale pixel
//   in_ready   : stage accepts a pixel this cycle
//   out_valid  : edge pixel available
//   out_ready  : downstream accepts out_pix/out_addr
//   out_pix    : 2-bit edge intensity
//   out_addr   : y*IMG_W+x of the window centre
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
module sobel_stage #(
    parameter int          IMG_W  = 160,
    parameter int          IMG_H  = 120,
    parameter logic [7:0]  THRESH = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [7:0]  in_pix,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_pix,
    output logic [14:0] out_addr,
    output logic        frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0] x_cnt, x_eff;
    logic [YW-1:0] y_cnt, y_eff;
    logic          fire, produce, last_pix;

    // Line buffers: lb1 holds row y-1, lb2 holds row y-2, indexed by column.
    logic [7:0] lb1 [IMG_W];
    logic [7:0] lb2 [IMG_W];

    // Window columns x-2 (p?0) and x-1 (p?1) are registered; column x (p?2)
    // is the live column {lb2[x], lb1[x], in_pix}, so the full 3x3 window
    // is complete in the same cycle the pixel is accepted.
    logic [7:0] p00, p01, p10, p11, p20, p21;
    logic [7:0] p02, p12, p22;

    logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [10:0] abs_gx, abs_gy, mag;
    logic [1:0]  pix_code;
    logic [14:0] addr_calc;

    assign in_ready = !out_valid || out_ready;
    assign fire     = in_valid && in_ready;

    // A start-of-frame pixel is (0,0) regardless of what the counters hold.
    assign x_eff = in_sof ? '0 : x_cnt;
    assign y_eff = in_sof ? '0 : y_cnt;

    assign produce  = fire && (x_eff >= XW'(2)) && (y_eff >= YW'(2));
    assign last_pix = (x_eff == X_LAST) && (y_eff == Y_LAST);

    assign p02 = lb2[x_eff];
    assign p12 = lb1[x_eff];
    assign p22 = in_pix;

    // Gx/Gy split into non-negative halves; |G| is the larger minus the
    // smaller, which keeps everything unsigned and inside 11 bits.
    assign gx_pos = {3'b000, p02} + {2'b00, p12, 1'b0} + {3'b000, p22};
    assign gx_neg = {3'b000, p00} + {2'b00, p10, 1'b0} + {3'b000, p20};
    assign gy_pos = {3'b000, p20} + {2'b00, p21, 1'b0} + {3'b000, p22};
    assign gy_neg = {3'b000, p00} + {2'b00, p01, 1'b0} + {3'b000, p02};

    assign abs_gx = (gx_pos >= gx_neg) ? (gx_pos - gx_neg) : (gx_neg - gx_pos);
    assign abs_gy = (gy_pos >= gy_neg) ? (gy_pos - gy_neg) : (gy_neg - gy_pos);
    assign mag    = abs_gx + abs_gy;

`ifdef SOBEL_THRESHOLD_EN
    // Comparing the unsaturated magnitude is equivalent: anything above 255
    // saturates to 255, which is >= any 8-bit threshold.
    assign pix_code = (mag >= 11'(THRESH)) ? 2'b11 : 2'b00;
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
    assign pix_code = (mag > 11'd255) ? 2'b11 : mag[7:6];
`endif

    // Centre of the window is one column and one row behind the new pixel.
    assign addr_calc = (15'(y_eff) - 15'd1) * 15'(IMG_W) + 15'(x_eff) - 15'd1;

    // Line buffers are deliberately not reset: outputs only start once two
    // full rows of the current frame have been written.
    always_ff @(posedge clk) begin
        if (fire) begin
            lb1[x_eff] <= in_pix;
            lb2[x_eff] <= lb1[x_eff];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
            p00   <= '0;
            p01   <= '0;
            p10   <= '0;
            p11   <= '0;
            p20   <= '0;
            p21   <= '0;
        end else if (fire) begin
            p00 <= p01;
            p01 <= p02;
            p10 <= p11;
            p11 <= p12;
            p20 <= p21;
            p21 <= p22;
            if (x_eff == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_eff == Y_LAST) ? '0 : y_eff + YW'(1);
            end else begin
                x_cnt <= x_eff + XW'(1);
                y_cnt <= y_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_pix    <= '0;
            out_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fire && last_pix;
            // produce can only happen when the slot is free or draining,
            // because fire requires in_ready.
            if (produce) begin
                out_valid <= 1'b1;
                out_pix   <= pix_code;
                out_addr  <= addr_calc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stage.sv
module tb_sobel_stage;

    localparam int W = 8;
    localparam int H = 8;

`ifdef SOBEL_THRESHOLD_EN
    localparam int P64  = 3;
    localparam int P100 = 3;
`else
    localparam int P64  = 1;
    localparam int P100 = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_pix;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_pix;
    logic [14:0] out_addr;
    logic        frame_done;

    sobel_stage #(.IMG_W(W), .IMG_H(H), .THRESH(8'd64)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pix     (in_pix),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pix    (out_pix),
        .out_addr   (out_addr),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (whole-image Sobel) ----------------
    typedef struct {
        int addr;
        int pix;
    } exp_t;

    int   img [H][W];
    int   mx = 0;
    int   my = 0;
    exp_t expq[$];

    function automatic int code_of(input int m);
        int s;
        s = (m > 255) ? 255 : m;
`ifdef SOBEL_THRESHOLD_EN
        return (s >= 64) ? 3 : 0;
`else
        return s / 64;
`endif
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_accept(input int pix, input bit sof, output bit last);
        int gx, gy, cx, cy;
        exp_t e;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        img[my][mx] = pix;
        if (mx >= 2 && my >= 2) begin
            cx = mx - 1;
            cy = my - 1;
            gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
               - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
            gy = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
               - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
            e.addr = cy * W + cx;
            e.pix  = code_of(iabs(gx) + iabs(gy));
            expq.push_back(e);
        end
        last = (mx == W-1) && (my == H-1);
        if (mx == W-1) begin
            mx = 0;
            my = (my == H-1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
    endtask

    // ---------------- monitor ----------------
    int rx_pix [W*H];
    int rx_cnt = 0;
    int rx_first = -1;
    int fd_seen = 0;
    int stall_cycles = 0;
    bit prev_stall = 0;
    int prev_pix = 0;
    int prev_addr = 0;
    bit rdy_random = 0;

    always @(negedge clk) begin
        if (rdy_random) out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_pix", out_pix, prev_pix);
                check("hold_addr", out_addr, prev_addr);
            end
            if (out_valid && !out_ready) begin
                check("in_ready_stall", in_ready, 0);
                stall_cycles++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_output", out_addr, -1);
                end else begin
                    e = expq.pop_front();
                    check("out_addr", out_addr, e.addr);
                    check("out_pix", out_pix, e.pix);
                end
                if (rx_cnt == 0) rx_first = out_addr;
                if (out_addr < W*H) rx_pix[out_addr] = out_pix;
                rx_cnt++;
            end
            if (frame_done) fd_seen++;
            prev_stall = out_valid && !out_ready;
            prev_pix   = out_pix;
            prev_addr  = out_addr;
        end
    end

    // ---------------- driver ----------------
    task automatic send(input int pix, input bit sof);
        bit acc;
        bit last;
        acc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_pix   = 8'(pix);
        in_sof   = sof;
        for (int k = 0; k < 300 && !acc; k++) begin
            #3;
            acc = in_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        if (!acc) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            return;
        end
        model_accept(pix, sof, last);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (last) check("frame_done_pulse", frame_done, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (expq.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("drain_empty", expq.size(), 0);
    endtask

    task automatic clear_rx();
        for (int i = 0; i < W*H; i++) rx_pix[i] = -1;
        rx_cnt   = 0;
        rx_first = -1;
    endtask

    task automatic random_frame(input bit gaps, input bit use_sof);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
                send(int'($urandom_range(0, 255)), use_sof && x == 0 && y == 0);
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int kind;   // 0: vertical step of height h at column 4, 1: linear ramp
        int h;
        int base;
        int dx;
        int dy;
        int exp_pix;
    } vec_t;

    vec_t tbl [7];

    function automatic int tbl_pixel(input vec_t v, input int x, input int y);
        if (v.kind == 0) return (x < 4) ? 0 : v.h;
        return v.base + v.dx * x + v.dy * y;
    endfunction

    function automatic int tbl_expect(input vec_t v, input int cx);
        if (v.kind == 0) return (cx == 3 || cx == 4) ? v.exp_pix : 0;
        return v.exp_pix;
    endfunction

    initial begin
        int fd0, st0, border;
        bit dummy;

        tbl[0] = '{kind: 1, h: 0,   base: 128, dx: 0, dy: 0, exp_pix: 0};     // flat
        tbl[1] = '{kind: 0, h: 255, base: 0,   dx: 0, dy: 0, exp_pix: 3};     // mag 1020
        tbl[2] = '{kind: 0, h: 25,  base: 0,   dx: 0, dy: 0, exp_pix: P100};  // mag 100
        tbl[3] = '{kind: 0, h: 10,  base: 0,   dx: 0, dy: 0, exp_pix: 0};     // mag 40
        tbl[4] = '{kind: 1, h: 0,   base: 20,  dx: 5, dy: 0, exp_pix: 0};     // |Gx|=40
        tbl[5] = '{kind: 1, h: 0,   base: 20,  dx: 4, dy: 4, exp_pix: P64};   // mag 64
        tbl[6] = '{kind: 1, h: 0,   base: 20,  dx: 2, dy: 5, exp_pix: 0};     // mag 56

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_pix    = 8'd0;
        out_ready = 1'b1;
        dummy     = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pix", out_pix, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_frame_done", frame_done, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed frames from the table.
        for (int t = 0; t < 7; t++) begin
            clear_rx();
            fd0 = fd_seen;
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    send(tbl_pixel(tbl[t], x, y), x == 0 && y == 0);
            drain();
            check("tbl_count", rx_cnt, 36);
            check("tbl_frame_done", fd_seen - fd0, 1);
            border = 0;
            for (int cy = 0; cy < H; cy++) begin
                for (int cx = 0; cx < W; cx++) begin
                    if (cx == 0 || cy == 0 || cx == W-1 || cy == H-1) begin
                        if (rx_pix[cy*W+cx] != -1) border++;
                    end else begin
                        check($sformatf("tbl%0d_pix_%0d_%0d", t, cx, cy),
                              rx_pix[cy*W+cx], tbl_expect(tbl[t], cx));
                    end
                end
            end
            check("tbl_border_untouched", border, 0);
        end

        // Backpressure: hold out_ready low for 5 cycles mid-stream.
        clear_rx();
        fd0 = fd_seen;
        st0 = stall_cycles;
        fork
            random_frame(0, 1);
            begin
                for (int k = 0; k < 2000 && !(my == 4 && mx == 4); k++) @(negedge clk);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", rx_cnt, 36);
        check("bp_frame_done", fd_seen - fd0, 1);
        check("bp_stall_seen", (stall_cycles - st0 >= 4) ? 1 : 0, 1);

        // Start of frame at (5,3) abandons the frame in progress.
        fd0 = fd_seen;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < W; x++)
                if (!(y == 3 && x >= 5)) send(int'($urandom_range(0, 255)), x == 0 && y == 0);
        drain();
        clear_rx();
        random_frame(0, 1);
        drain();
        check("sof_count", rx_cnt, 36);
        check("sof_first_addr", rx_first, 9);
        check("sof_frame_done", fd_seen - fd0, 1);

        // Reset while an output is pending.
        out_ready = 1'b0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < W; x++)
                if (y < 2 || x <= 2) send(int'($urandom_range(0, 255)), x == 0 && y == 0);
        check("pre_reset_valid", out_valid, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_clears_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        expq.delete();
        mx = 0;
        my = 0;
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        clear_rx();
        fd0 = fd_seen;
        random_frame(0, 0);
        drain();
        check("post_reset_count", rx_cnt, 36);
        check("post_reset_first_addr", rx_first, 9);
        check("post_reset_frame_done", fd_seen - fd0, 1);

        // Randomised frames with input gaps and random downstream stalls.
        fd0 = fd_seen;
        rdy_random = 1;
        for (int f = 0; f < 4; f++) random_frame(1, f[0]);
        drain();
        rdy_random = 0;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rand_frame_done", fd_seen - fd0, 4);
        check("final_queue_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
